// File: rtl/y86_alu.sv
// Registered Y86-64 execute-stage ALU with ZF/SF/OF condition codes and jXX/cmovXX condition evaluation.
// Optional ALU_CARRY_EN adds a registered carry/borrow output and a CF condition-code register.
module y86_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       alufun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    input  logic [3:0]       cond_fun,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zf,
    output logic             sf,
    output logic             of,
`ifdef ALU_CARRY_EN
    output logic             carry,
`endif
    output logic             cnd
);

    // Signed overflow of b + a: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of b - a: operands differ in sign, result sign departs from b.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != b_msb);
    endfunction

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] res_s;
    logic             ovf_s;
    logic [WIDTH-1:0] result_r;
    logic             overflow_r;
    logic             out_valid_r;
    logic             zf_r;
    logic             sf_r;
    logic             of_r;
    logic             cnd_s;

`ifdef ALU_CARRY_EN
    logic [WIDTH:0]   sum_wide_s;
    logic [WIDTH:0]   diff_wide_s;
    logic             carry_s;
    logic             carry_r;
    logic             cf_r;

    // Extra top bit captures carry-out on add and borrow on sub.
    assign sum_wide_s  = {1'b0, b} + {1'b0, a};
    assign diff_wide_s = {1'b0, b} - {1'b0, a};
    assign sum_s       = sum_wide_s[WIDTH-1:0];
    assign diff_s      = diff_wide_s[WIDTH-1:0];
`else
    assign sum_s  = b + a;
    assign diff_s = b - a;
`endif

    // Select the operation result and its signed overflow.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        ovf_s = 1'b0;
`ifdef ALU_CARRY_EN
        carry_s = 1'b0;
`endif
        case (alufun)
            2'd0: begin
                res_s = sum_s;
                ovf_s = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
`ifdef ALU_CARRY_EN
                carry_s = sum_wide_s[WIDTH];
`endif
            end
            2'd1: begin
                res_s = diff_s;
                ovf_s = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_s[WIDTH-1]);
`ifdef ALU_CARRY_EN
                carry_s = diff_wide_s[WIDTH];
`endif
            end
            2'd2: res_s = a & b;
            2'd3: res_s = a ^ b;
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Result and condition-code registers; flags only move on a valid op that requests it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r    <= {WIDTH{1'b0}};
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            zf_r        <= 1'b1;
            sf_r        <= 1'b0;
            of_r        <= 1'b0;
`ifdef ALU_CARRY_EN
            carry_r     <= 1'b0;
            cf_r        <= 1'b0;
`endif
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                result_r   <= res_s;
                overflow_r <= ovf_s;
`ifdef ALU_CARRY_EN
                carry_r    <= carry_s;
`endif
                if (set_cc) begin
                    zf_r <= (res_s == {WIDTH{1'b0}});
                    sf_r <= res_s[WIDTH-1];
                    of_r <= ovf_s;
`ifdef ALU_CARRY_EN
                    cf_r <= carry_s;
`endif
                end
            end
        end
    end

    // Y86 condition decode from the held flags; unused encodings never fire.
    always_comb begin
        cnd_s = 1'b0;
        case (cond_fun)
            4'd0:    cnd_s = 1'b1;
            4'd1:    cnd_s = (sf_r ^ of_r) | zf_r;
            4'd2:    cnd_s = sf_r ^ of_r;
            4'd3:    cnd_s = zf_r;
            4'd4:    cnd_s = ~zf_r;
            4'd5:    cnd_s = ~(sf_r ^ of_r);
            4'd6:    cnd_s = ~(sf_r ^ of_r) & ~zf_r;
            default: cnd_s = 1'b0;
        endcase
    end

    assign result    = result_r;
    assign overflow  = overflow_r;
    assign out_valid = out_valid_r;
    assign zf        = zf_r;
    assign sf        = sf_r;
    assign of        = of_r;
    assign cnd       = cnd_s;
`ifdef ALU_CARRY_EN
    assign carry     = carry_r;
`endif

endmodule

// File: tb/tb_y86_alu.sv
// Self-checking bench for y86_alu: directed vector table, reset sequences and a randomized run
// against an arithmetic reference model.
module tb_y86_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  alufun = 2'd0;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic        set_cc = 1'b0;
    logic [3:0]  cond_fun = 4'd0;
    logic        out_valid;
    logic [63:0] result;
    logic        overflow;
    logic        zf, sf, of, cnd;
`ifdef ALU_CARRY_EN
    logic        carry;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    y86_alu #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alufun(alufun),
        .a(a), .b(b), .set_cc(set_cc), .cond_fun(cond_fun),
        .out_valid(out_valid), .result(result), .overflow(overflow),
        .zf(zf), .sf(sf), .of(of),
`ifdef ALU_CARRY_EN
        .carry(carry),
`endif
        .cnd(cnd)
    );

    typedef struct {
        logic        iv;
        logic [1:0]  fn;
        logic [63:0] va;
        logic [63:0] vb;
        logic        sc;
        logic [3:0]  cf;
        logic [63:0] r;
        logic        ov;
        logic        vld;
        logic        ezf;
        logic        esf;
        logic        eof;
        logic        ecnd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [1:0] fn, input logic [63:0] va,
                                input logic [63:0] vb, input logic sc, input logic [3:0] cf,
                                input logic [63:0] r, input logic ov, input logic vld,
                                input logic ezf, input logic esf, input logic eof, input logic ecnd);
        vec_t v;
        v.iv = iv; v.fn = fn; v.va = va; v.vb = vb; v.sc = sc; v.cf = cf;
        v.r = r; v.ov = ov; v.vld = vld; v.ezf = ezf; v.esf = esf; v.eof = eof; v.ecnd = ecnd;
        return v;
    endfunction

    // Reference model state
    logic [63:0] m_res;
    logic        m_ov, m_vld, m_zf, m_sf, m_of, m_carry;

    function automatic logic model_cnd(input logic [3:0] f, input logic z, input logic s, input logic o);
        logic lt;
        lt = s ^ o;
        if (f == 4'd0) return 1'b1;
        if (f == 4'd1) return lt || z;
        if (f == 4'd2) return lt;
        if (f == 4'd3) return z;
        if (f == 4'd4) return !z;
        if (f == 4'd5) return !lt;
        if (f == 4'd6) return !lt && !z;
        return 1'b0;
    endfunction

    // Apply one cycle of inputs to the model using exact (unbounded) arithmetic.
    task automatic model_step(input logic iv, input logic [1:0] fn, input logic [63:0] va,
                              input logic [63:0] vb, input logic sc);
        logic signed [65:0] exact;
        logic [64:0]        uwide;
        logic [63:0]        r;
        logic               ov, cy;
        r = 64'd0; ov = 1'b0; cy = 1'b0;
        case (fn)
            2'd0: begin
                exact = $signed({{2{vb[63]}}, vb}) + $signed({{2{va[63]}}, va});
                uwide = {1'b0, vb} + {1'b0, va};
                r  = uwide[63:0];
                cy = uwide[64];
                ov = (exact > 66'sd9223372036854775807) || (exact < -66'sd9223372036854775808);
            end
            2'd1: begin
                exact = $signed({{2{vb[63]}}, vb}) - $signed({{2{va[63]}}, va});
                r  = vb - va;
                cy = (vb < va);
                ov = (exact > 66'sd9223372036854775807) || (exact < -66'sd9223372036854775808);
            end
            2'd2: r = va & vb;
            default: r = va ^ vb;
        endcase
        m_vld = iv;
        if (iv) begin
            m_res = r; m_ov = ov; m_carry = cy;
            if (sc) begin
                m_zf = (r == 64'd0); m_sf = r[63]; m_of = ov;
            end
        end
    endtask

    task automatic model_reset();
        m_res = 64'd0; m_ov = 1'b0; m_vld = 1'b0; m_carry = 1'b0;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    endtask

    task automatic drive(input logic iv, input logic [1:0] fn, input logic [63:0] va,
                         input logic [63:0] vb, input logic sc, input logic [3:0] cf);
        in_valid = iv; alufun = fn; a = va; b = vb; set_cc = sc; cond_fun = cf;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_result"}, result, 64'd0);
        chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_zf"}, {63'd0, zf}, 64'd1);
        chk({tag, "_sf"}, {63'd0, sf}, 64'd0);
        chk({tag, "_of"}, {63'd0, of}, 64'd0);
        chk({tag, "_cnd_e"}, {63'd0, cnd}, 64'd1);
`ifdef ALU_CARRY_EN
        chk({tag, "_carry"}, {63'd0, carry}, 64'd0);
`endif
    endtask

    logic [7:0] sweep_exp;
    logic [63:0] ra, rb;

    initial begin
        model_reset();
        // Asynchronous reset between clock edges
        #12;
        cond_fun = 4'd3;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = mk(1'b1, 2'd0, 64'd5, 64'd7, 1'b1, 4'd6, 64'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[1] = mk(1'b1, 2'd1, 64'h10, 64'h10, 1'b1, 4'd3, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[2] = mk(1'b1, 2'd1, 64'd3, 64'd1, 1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[3] = mk(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'd5,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[4] = mk(1'b1, 2'd2, 64'hF0F0, 64'hFF00, 1'b0, 4'd2, 64'hF000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[5] = mk(1'b1, 2'd3, 64'hF0F0, 64'hFF00, 1'b0, 4'd1, 64'h0FF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[6] = mk(1'b0, 2'd0, 64'd1, 64'd1, 1'b1, 4'd6, 64'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[7] = mk(1'b1, 2'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 4'd2,
                     64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].fn, vecs[i].va, vecs[i].vb, vecs[i].sc, vecs[i].cf);
            model_step(vecs[i].iv, vecs[i].fn, vecs[i].va, vecs[i].vb, vecs[i].sc);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_result", i), result, vecs[i].r);
            chk($sformatf("vec%0d_overflow", i), {63'd0, overflow}, {63'd0, vecs[i].ov});
            chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].vld});
            chk($sformatf("vec%0d_zf", i), {63'd0, zf}, {63'd0, vecs[i].ezf});
            chk($sformatf("vec%0d_sf", i), {63'd0, sf}, {63'd0, vecs[i].esf});
            chk($sformatf("vec%0d_of", i), {63'd0, of}, {63'd0, vecs[i].eof});
            chk($sformatf("vec%0d_cnd", i), {63'd0, cnd}, {63'd0, vecs[i].ecnd});
        end

        // Condition sweep with zf=0, sf=1, of=0
        @(negedge clk);
        drive(1'b1, 2'd1, 64'd3, 64'd1, 1'b1, 4'd0);
        model_step(1'b1, 2'd1, 64'd3, 64'd1, 1'b1);
        @(negedge clk);
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
        model_step(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
        sweep_exp = 8'b0001_0111;
        for (int c = 0; c < 16; c++) begin
            cond_fun = 4'(c);
            #1;
            chk($sformatf("sweep_cnd%0d", c), {63'd0, cnd}, (c < 8) ? {63'd0, sweep_exp[c]} : 64'd0);
        end

        // Reset asserted while an operation is in flight across an edge
        @(negedge clk);
        drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd3);
        rst_n = 1'b0;
        #1;
        check_reset_state("inflight_reset");
        @(posedge clk);
        #1;
        check_reset_state("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Mid-stream reset right after a flag-setting result lands
        @(negedge clk);
        drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd3);
        @(posedge clk);
        #1;
        chk("pre_reset_result", result, 64'h8000_0000_0000_0000);
        rst_n = 1'b0;
        #1;
        check_reset_state("midstream_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized run against the reference model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = 64'h8000_0000_0000_0000;
                2: rb = 64'h7FFF_FFFF_FFFF_FFFF;
                3: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ra, rb,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            model_step(in_valid, alufun, a, b, set_cc);
            @(posedge clk);
            #1;
            chk("rnd_result", result, m_res);
            chk("rnd_overflow", {63'd0, overflow}, {63'd0, m_ov});
            chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, m_vld});
            chk("rnd_zf", {63'd0, zf}, {63'd0, m_zf});
            chk("rnd_sf", {63'd0, sf}, {63'd0, m_sf});
            chk("rnd_of", {63'd0, of}, {63'd0, m_of});
            chk("rnd_cnd", {63'd0, cnd}, {63'd0, model_cnd(cond_fun, m_zf, m_sf, m_of)});
`ifdef ALU_CARRY_EN
            chk("rnd_carry", {63'd0, carry}, {63'd0, m_carry});
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
